rle_decode_ctrl: RTL

RLE_DECODE_CTRL -- requirements
Module: rle_decode_ctrl

---
 rtl/rle_decode_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rle_decode_ctrl.sv
// rle_decode_ctrl: run-length decoder that fetches one compressed stream
// byte-by-byte from memory and assembles 256-bit decompressed lines.
// Each byte carries a bit value (bit 7) and a run length (bits 6:0).
// A run length of 0 terminates the stream.
// Lines fill MSB-first. A finished line is held on line_out until the
// consumer accepts it.
// Optional feature: define RLE_DECODE_BYTE_LIMIT_EN to cap a stream at
// MAX_BYTES fetched bytes. An overrun raises err, and the stream then
// finishes through the flush path.

module rle_decode_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int MAX_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_valid,
    output logic [255:0]      line_out,
    output logic              line_valid,
    input  logic              line_ready,
    output logic [15:0]       line_cnt,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXPAND,
        EMIT,
        FLUSH,
        FIN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_q;
    logic              run_val;
    logic [6:0]        run_rem;
    logic [8:0]        bitpos;
    logic [255:0]      line_buf;
    logic              emit_to_fin;
    logic              limit_hit;

    logic [8:0]        space;
    logic [8:0]        take;
    logic [8:0]        shift;
    logic [255:0]      mask;
    logic [8:0]        next_bitpos;
    logic [6:0]        next_rem;

    assign mem_addr = addr;
    assign line_out = line_buf;
    assign err      = limit_hit;

    // Work out how many run bits fit this cycle and where they land in the line
    always_comb begin
        space = 9'd256 - bitpos;
        take  = {2'b00, run_rem};
        if (take > 9'd8) begin
            take = 9'd8;
        end
        if (take > space) begin
            take = space;
        end
        shift       = space - take;
        mask        = ((256'd1 << take) - 256'd1) << shift;
        next_bitpos = bitpos + take;
        next_rem    = run_rem - take[6:0];
    end

`ifdef RLE_DECODE_BYTE_LIMIT_EN
    logic [31:0] byte_cnt;
    logic        limit_now;

    assign limit_now = (byte_cnt + 32'd1) >= 32'(MAX_BYTES);

    // Count fetched bytes and flag a stream that reaches the cap without terminating
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= 32'd0;
            limit_hit <= 1'b0;
        end else if (state == IDLE && start) begin
            byte_cnt  <= 32'd0;
            limit_hit <= 1'b0;
        end else if (state == FETCH && mem_valid) begin
            byte_cnt <= byte_cnt + 32'd1;
            if (limit_now && mem_data[6:0] != 7'd0) begin
                limit_hit <= 1'b1;
            end
        end
    end
`else
    logic unused_max_bytes;

    assign limit_hit        = 1'b0;
    assign unused_max_bytes = (MAX_BYTES != 0);
`endif

    // Main decoder state machine; all outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            data_q      <= 8'd0;
            run_val     <= 1'b0;
            run_rem     <= 7'd0;
            bitpos      <= 9'd0;
            line_buf    <= '0;
            emit_to_fin <= 1'b0;
            mem_rd      <= 1'b0;
            busy        <= 1'b0;
            line_valid  <= 1'b0;
            done        <= 1'b0;
            line_cnt    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr     <= base_addr;
                        line_cnt <= 16'd0;
                        bitpos   <= 9'd0;
                        line_buf <= '0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_valid) begin
                        data_q <= mem_data;
                        addr   <= addr + 1'b1;
                        mem_rd <= 1'b0;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    if (data_q[6:0] == 7'd0) begin
                        state <= FLUSH;
                    end else begin
                        run_val <= data_q[7];
                        run_rem <= data_q[6:0];
                        state   <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (run_val) begin
                        line_buf <= line_buf | mask;
                    end
                    bitpos  <= next_bitpos;
                    run_rem <= next_rem;
                    if (next_bitpos == 9'd256) begin
                        line_valid  <= 1'b1;
                        emit_to_fin <= 1'b0;
                        state       <= EMIT;
                    end else if (next_rem == 7'd0) begin
                        if (limit_hit) begin
                            state <= FLUSH;
                        end else begin
                            mem_rd <= 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                EMIT: begin
                    if (line_ready) begin
                        line_valid <= 1'b0;
                        line_cnt   <= line_cnt + 16'd1;
                        bitpos     <= 9'd0;
                        line_buf   <= '0;
                        if (emit_to_fin) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            state <= EXPAND;
                        end
                    end
                end
                FLUSH: begin
                    if (bitpos != 9'd0) begin
                        line_valid  <= 1'b1;
                        emit_to_fin <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
